linecounter: RTL and testbench

Pipelined Hamming-weight (popcount) stage directly downstream of the SAD XOR stage. Reduces each WIDTH-bit mismatch vector to a mismatch score in a fixed 3-cycle pipeline, one vector per clock. Tracks the minimum score and its position within a frame, marked by in_first/in_last, and reports the best-match position to the match/output logic.

---
 rtl/linecounter_pkg.sv | 24 ++
 rtl/linecounter_popcount_chunk.sv | 23 ++
 rtl/linecounter.sv | 159 +++++++++++++++
 tb/tb_linecounter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/linecounter_pkg.sv
// Shared constants for the linecounter popcount pipeline: vector geometry and derived widths.
package linecounter_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int WIDTH   = 4000;
  localparam int CHUNK   = 16;
  localparam int GROUP   = 16;
  localparam int POS_W   = 16;

  localparam int SCORE_W = clog2(WIDTH + 1);
  localparam int CHUNK_W = clog2(CHUNK + 1);
  localparam int N_CHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int N_GROUP = (N_CHUNK + GROUP - 1) / GROUP;
  localparam int GSUM_W  = clog2(GROUP * CHUNK + 1);

endpackage

// File: rtl/linecounter_popcount_chunk.sv
// Combinational Hamming weight of one CHUNK-bit slice via a pairwise adder tree.
// Zero latency, no flow control.
module popcount_chunk
  import linecounter_pkg::*;
(
  input  logic [CHUNK-1:0]   bits,
  output logic [CHUNK_W-1:0] count
);

  // Tree is laid out as an implicit binary heap over a power-of-two leaf row.
  localparam int LEAVES = 1 << clog2(CHUNK);

  logic [CHUNK_W-1:0] node [2*LEAVES-1];

  always_comb begin
    for (int i = 0; i < 2*LEAVES-1; i++) node[i] = '0;
    for (int i = 0; i < CHUNK; i++) node[LEAVES-1+i] = CHUNK_W'(bits[i]);
    for (int i = LEAVES-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
  end

  assign count = node[0];

endmodule

// File: rtl/linecounter.sv
// Popcount of each mismatch vector in 3 cycles (1/clk, no backpressure) with per-frame min tracker
// committing one cycle later; tracker and position counter exist only with LINECOUNTER_BEST_EN.
module linecounter
  import linecounter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  output logic [POS_W-1:0]   score_pos,
  output logic [SCORE_W-1:0] best_score,
  output logic [POS_W-1:0]   best_pos,
  output logic               best_valid
);

  logic [N_CHUNK*CHUNK-1:0] d_pad;
  logic [CHUNK_W-1:0]       chunk_cnt [N_CHUNK];
  logic [CHUNK_W-1:0]       s1_cnt    [N_CHUNK];
  logic [GSUM_W-1:0]        grp_sum   [N_GROUP];
  logic [GSUM_W-1:0]        s2_sum    [N_GROUP];
  logic [31:0]              acc;
  logic                     s1_vld;
  logic                     s2_vld;

  always_comb begin
    d_pad = '0;
    d_pad[WIDTH-1:0] = d_in;
  end

  for (genvar c = 0; c < N_CHUNK; c++) begin : g_chunk
    popcount_chunk u_pc (
      .bits  (d_pad[c*CHUNK +: CHUNK]),
      .count (chunk_cnt[c])
    );
  end

  // The last group may be partial; indices past N_CHUNK contribute nothing.
  always_comb begin
    for (int g = 0; g < N_GROUP; g++) begin
      grp_sum[g] = '0;
      for (int k = 0; k < GROUP; k++) begin
        if (g*GROUP + k < N_CHUNK) begin
          grp_sum[g] = grp_sum[g] + GSUM_W'(s1_cnt[(g*GROUP + k < N_CHUNK) ? g*GROUP + k : 0]);
        end
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int g = 0; g < N_GROUP; g++) acc = acc + 32'(s2_sum[g]);
  end

  always_ff @(posedge clk) begin
    if (in_valid) s1_cnt <= chunk_cnt;
    if (s1_vld)   s2_sum <= grp_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      score_valid <= 1'b0;
      score       <= '0;
    end else begin
      s1_vld      <= in_valid;
      s2_vld      <= s1_vld;
      score_valid <= s2_vld;
      if (s2_vld) score <= acc[SCORE_W-1:0];
    end
  end

`ifdef LINECOUNTER_BEST_EN
  logic [POS_W-1:0]   pos_cnt;
  logic [POS_W-1:0]   beat_pos;
  logic [POS_W-1:0]   s1_pos;
  logic [POS_W-1:0]   s2_pos;
  logic               s1_first, s2_first, s3_first;
  logic               s1_last, s2_last, s3_last;
  logic [SCORE_W-1:0] run_min;
  logic [POS_W-1:0]   run_pos;
  logic [SCORE_W-1:0] cand_min;
  logic [POS_W-1:0]   cand_pos;

  assign beat_pos = in_first ? '0 : pos_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_cnt   <= '0;
      s1_first  <= 1'b0;
      s2_first  <= 1'b0;
      s3_first  <= 1'b0;
      s1_last   <= 1'b0;
      s2_last   <= 1'b0;
      s3_last   <= 1'b0;
      s1_pos    <= '0;
      s2_pos    <= '0;
      score_pos <= '0;
    end else begin
      if (in_valid) pos_cnt <= beat_pos + 1'b1;
      s1_first <= in_valid & in_first;
      s1_last  <= in_valid & in_last;
      s2_first <= s1_vld & s1_first;
      s2_last  <= s1_vld & s1_last;
      s3_first <= s2_vld & s2_first;
      s3_last  <= s2_vld & s2_last;
      if (in_valid) s1_pos    <= beat_pos;
      if (s1_vld)   s2_pos    <= s1_pos;
      if (s2_vld)   score_pos <= s2_pos;
    end
  end

  // Strict less-than keeps the earliest position on ties.
  always_comb begin
    cand_min = run_min;
    cand_pos = run_pos;
    if (s3_first || (score < run_min)) begin
      cand_min = score;
      cand_pos = score_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_min    <= '1;
      run_pos    <= '0;
      best_score <= '0;
      best_pos   <= '0;
      best_valid <= 1'b0;
    end else begin
      best_valid <= 1'b0;
      if (score_valid) begin
        if (s3_last) begin
          best_score <= cand_min;
          best_pos   <= cand_pos;
          best_valid <= 1'b1;
          run_min    <= '1;
          run_pos    <= '0;
        end else begin
          run_min <= cand_min;
          run_pos <= cand_pos;
        end
      end
    end
  end
`else
  logic unused_sideband;
  assign unused_sideband = in_first ^ in_last;
  assign score_pos  = '0;
  assign best_score = '0;
  assign best_pos   = '0;
  assign best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_linecounter.sv
// Directed, table-driven bench for linecounter: score path, frame tracker and reset corners.
module tb_linecounter;
  import linecounter_pkg::*;

`ifdef LINECOUNTER_BEST_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [WIDTH-1:0]   d_in;
  logic               in_valid, in_first, in_last;
  logic [SCORE_W-1:0] score, best_score;
  logic [POS_W-1:0]   score_pos, best_pos;
  logic               score_valid, best_valid;

  always #5 clk = ~clk;

  linecounter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_in        (d_in),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_last     (in_last),
    .score       (score),
    .score_valid (score_valid),
    .score_pos   (score_pos),
    .best_score  (best_score),
    .best_pos    (best_pos),
    .best_valid  (best_valid)
  );

  // nb: number of low bits set (-1 = only the top bit); sc/pos: expected score output;
  // bs/bp: expected commit when the row is a valid last beat.
  typedef struct {
    bit vld; bit first; bit last; int nb; int sc; int pos; int bs; int bp;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];
  int errors = 0;
  int checks = 0;

  function automatic logic [WIDTH-1:0] pattern(input int nb);
    logic [WIDTH-1:0] p;
    p = '0;
    if (nb < 0) p[WIDTH-1] = 1'b1;
    else for (int i = 0; i < nb; i++) p[i] = 1'b1;
    return p;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit f, input bit l, input int nb);
    in_valid = v;
    in_first = f;
    in_last  = l;
    d_in     = pattern(nb);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " score_valid"}, score_valid, 0);
    chk({tag, " score"},       score, 0);
    chk({tag, " score_pos"},   score_pos, 0);
    chk({tag, " best_valid"},  best_valid, 0);
    chk({tag, " best_score"},  best_score, 0);
    chk({tag, " best_pos"},    best_pos, 0);
  endtask

  initial begin
    vec_t r;
    //          vld f  l  nb    sc    pos bs  bp
    vec[0]  = '{1, 0, 0, 0,    0,    0,  0,  0};
    vec[1]  = '{1, 0, 0, 4000, 4000, 1,  0,  0};
    vec[2]  = '{1, 0, 1, -1,   1,    2,  0,  0};  // no frame opened since reset
    vec[3]  = '{1, 1, 0, 7,    7,    0,  0,  0};
    vec[4]  = '{1, 0, 0, 3,    3,    1,  0,  0};
    vec[5]  = '{1, 0, 0, 9,    9,    2,  0,  0};
    vec[6]  = '{1, 0, 0, 3,    3,    3,  0,  0};
    vec[7]  = '{1, 0, 1, 5,    5,    4,  3,  1};
    vec[8]  = '{1, 1, 1, 12,   12,   0,  12, 0};
    vec[9]  = '{1, 1, 0, 20,   20,   0,  0,  0};
    vec[10] = '{0, 1, 1, 63,   0,    0,  0,  0};  // sideband ignored when not valid
    vec[11] = '{1, 0, 0, 15,   15,   1,  0,  0};
    vec[12] = '{1, 0, 1, 25,   25,   2,  15, 1};
    vec[13] = '{1, 1, 0, 2,    2,    0,  0,  0};
    vec[14] = '{1, 1, 0, 30,   30,   0,  0,  0};  // restart discards the open frame
    vec[15] = '{1, 0, 1, 31,   31,   1,  30, 0};

    rst_n = 1'b0;
    drive(1, 1, 1, WIDTH);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    drive(0, 0, 0, 0);

    for (int t = 0; t <= NV + 3; t++) begin
      @(negedge clk);
      if (t >= 3 && t - 3 < NV) begin
        r = vec[t-3];
        chk($sformatf("row%0d score_valid", t-3), score_valid, r.vld);
        if (r.vld) begin
          chk($sformatf("row%0d score", t-3), score, r.sc);
          chk($sformatf("row%0d score_pos", t-3), score_pos, BEST_EN ? r.pos : 0);
        end
      end
      if (t >= 4) begin
        r = vec[t-4];
        chk($sformatf("row%0d best_valid", t-4), best_valid, BEST_EN && r.vld && r.last);
        if (BEST_EN && r.vld && r.last) begin
          chk($sformatf("row%0d best_score", t-4), best_score, r.bs);
          chk($sformatf("row%0d best_pos", t-4), best_pos, r.bp);
        end
      end
      if (t < NV) drive(vec[t].vld, vec[t].first, vec[t].last, vec[t].nb);
      else        drive(0, 0, 0, 0);
    end

    // Mid-frame reset with a gap: in-flight beats and the partial frame vanish.
    drive(1, 1, 0, 4);
    @(negedge clk); drive(0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 1);
    @(negedge clk); rst_n = 1'b0; drive(1, 0, 1, 2);
    @(negedge clk); rst_n = 1'b1; drive(0, 0, 0, 0);
    chk_all_zero("midreset");
    @(negedge clk);
    chk("post-reset idle score_valid", score_valid, 0);
    drive(1, 0, 0, 5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      chk($sformatf("resume k%0d score_valid", k), score_valid, k == 3);
      chk($sformatf("resume k%0d best_valid", k), best_valid, 0);
      if (k == 3) begin
        chk("resume score", score, 5);
        chk("resume score_pos", score_pos, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
